// File: rtl/regfile_sb.sv
// Multi-port register file with busy-bit scoreboard for multi-cycle producers.
// Optional write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter  int unsigned XLEN     = 64,
    parameter  int unsigned NREG     = 32,
    parameter  int unsigned NRD      = 3,
    parameter  int unsigned NWR      = 2,
    parameter  int unsigned ZERO_REG = 1,
    localparam int unsigned AW       = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    output logic                alloc_stall,
    input  logic                flush,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;

    logic [NREG-1:0] w_wr_hit;
    logic [XLEN-1:0] w_wr_val [NREG];
    logic [NREG-1:0] w_busy_nxt;
    logic            w_alloc_ok;
    logic            w_alloc_busy;
    logic            w_alloc_wr_match;

    // Addresses that hold real storage: in range and not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        addr_ok = (32'(a) < NREG) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Ports are scanned in ascending order so the highest-index writer wins.
    always_comb begin
        w_wr_hit = '0;
        for (int unsigned k = 0; k < NREG; k++) w_wr_val[k] = '0;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (wr_en[j] && addr_ok(wr_addr[j*AW +: AW])) begin
                w_wr_hit[wr_addr[j*AW +: AW]] = 1'b1;
                w_wr_val[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        w_alloc_wr_match = 1'b0;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == alloc_addr)) w_alloc_wr_match = 1'b1;
        end
    end

    assign w_alloc_ok   = addr_ok(alloc_addr);
    assign w_alloc_busy = w_alloc_ok && r_busy[alloc_addr];
    assign alloc_stall  = alloc_en && w_alloc_busy && !w_alloc_wr_match;

    // Set after clear so a same-edge alloc keeps the register owned; flush overrides both.
    always_comb begin
        w_busy_nxt = r_busy & ~w_wr_hit;
        if (alloc_en && !alloc_stall && w_alloc_ok) w_busy_nxt[alloc_addr] = 1'b1;
        if (flush) w_busy_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < NREG; k++) r_regs[k] <= '0;
            r_busy <= '0;
        end else begin
            for (int unsigned k = 0; k < NREG; k++) begin
                if (w_wr_hit[k]) r_regs[k] <= w_wr_val[k];
            end
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_vec = r_busy;

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            if (addr_ok(rd_addr[i*AW +: AW])) begin
                rd_data[i*XLEN +: XLEN] = r_regs[rd_addr[i*AW +: AW]];
                rd_busy[i]              = r_busy[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                for (int unsigned j = 0; j < NWR; j++) begin
                    if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
                        rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                        rd_busy[i]              = 1'b0;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: directed scenarios then random traffic,
// checked against an array-based model of the register file rules.
module tb_regfile_sb;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned NREG     = 32;
    localparam int unsigned NRD      = 3;
    localparam int unsigned NWR      = 2;
    localparam int unsigned ZERO_REG = 1;
    localparam int unsigned AW       = $clog2(NREG);

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic                alloc_stall;
    logic                flush;
    logic [NREG-1:0]     busy_vec;

    regfile_sb #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .ZERO_REG(ZERO_REG)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_stall(alloc_stall),
        .flush(flush), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        string               name;
        logic [NRD*XLEN-1:0] d;
        logic [NRD-1:0]      b;
        logic [NREG-1:0]     bv;
        logic                st;
    } exp_t;

    exp_t            q[$];
    event            ev_sample;
    int              checks = 0;
    int              passes = 0;
    logic [XLEN-1:0] m_reg  [NREG];
    logic            m_busy [NREG];

    function automatic void m_reset();
        for (int k = 0; k < NREG; k++) begin
            m_reg[k]  = '0;
            m_busy[k] = 1'b0;
        end
    endfunction

    function automatic logic wr_to(input logic [AW-1:0] a);
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && wr_addr[j*AW +: AW] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t predict(input string name);
        exp_t        e;
        logic [AW-1:0] a;
        e.name = name;
        e.d = '0;
        e.b = '0;
        for (int i = 0; i < NRD; i++) begin
            a = rd_addr[i*AW +: AW];
            if (ZERO_REG == 0 || a != 0) begin
                e.d[i*XLEN +: XLEN] = m_reg[a];
                e.b[i] = m_busy[a];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en[j] && wr_addr[j*AW +: AW] == a) begin
                        e.d[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                        e.b[i] = 1'b0;
                    end
                end
`endif
            end
        end
        for (int k = 0; k < NREG; k++) e.bv[k] = m_busy[k];
        e.st = alloc_en && m_busy[alloc_addr] && !wr_to(alloc_addr);
        return e;
    endfunction

    // Clock-edge rules: writes in port order, busy cleared by writeback, alloc sets, flush clears all.
    function automatic void model_update();
        logic         stall;
        logic [AW-1:0] a;
        stall = alloc_en && m_busy[alloc_addr] && !wr_to(alloc_addr);
        for (int j = 0; j < NWR; j++) begin
            a = wr_addr[j*AW +: AW];
            if (wr_en[j] && (ZERO_REG == 0 || a != 0)) begin
                m_reg[a]  = wr_data[j*XLEN +: XLEN];
                m_busy[a] = 1'b0;
            end
        end
        if (alloc_en && !stall && (ZERO_REG == 0 || alloc_addr != 0)) m_busy[alloc_addr] = 1'b1;
        if (flush) for (int k = 0; k < NREG; k++) m_busy[k] = 1'b0;
    endfunction

    task automatic check(input string name);
        #1;
        q.push_back(predict(name));
        -> ev_sample;
        #1;
    endtask

    task automatic step(input string name);
        check(name);
        @(posedge clk);
        if (rst) model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
    endtask

    task automatic set_wr(input int j, input int a, input logic [XLEN-1:0] d);
        wr_en[j] = 1'b1;
        wr_addr[j*AW +: AW] = AW'(a);
        wr_data[j*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int i, input int a);
        rd_addr[i*AW +: AW] = AW'(a);
    endtask

    task automatic set_alloc(input int a);
        alloc_en = 1'b1;
        alloc_addr = AW'(a);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(ev_sample);
            while (q.size() > 0) begin
                e = q.pop_front();
                for (int i = 0; i < NRD; i++) begin
                    checks++;
                    if (rd_data[i*XLEN +: XLEN] !== e.d[i*XLEN +: XLEN])
                        $display("FAIL %s rd_data%0d got=%h exp=%h", e.name, i,
                                 rd_data[i*XLEN +: XLEN], e.d[i*XLEN +: XLEN]);
                    else passes++;
                    checks++;
                    if (rd_busy[i] !== e.b[i])
                        $display("FAIL %s rd_busy%0d got=%b exp=%b", e.name, i, rd_busy[i], e.b[i]);
                    else passes++;
                end
                checks++;
                if (busy_vec !== e.bv)
                    $display("FAIL %s busy_vec got=%h exp=%h", e.name, busy_vec, e.bv);
                else passes++;
                checks++;
                if (alloc_stall !== e.st)
                    $display("FAIL %s alloc_stall got=%b exp=%b", e.name, alloc_stall, e.st);
                else passes++;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst = 1'b0;
        idle();
        m_reset();
        repeat (2) @(negedge clk);
        check("reset");
        rst = 1'b1;
        @(negedge clk);

        idle(); set_wr(0, 5, 64'hDEAD); set_alloc(6); step("pre_rst");
        idle(); set_rd(0, 5); set_rd(1, 6); set_alloc(6);
        check("pre_rst_read");
        rst = 1'b0;
        m_reset();
        check("rst_mid");
        rst = 1'b1;
        alloc_en = 1'b0;
        @(posedge clk); model_update(); @(negedge clk);
        idle(); set_rd(0, 5); set_rd(1, 6); set_rd(2, 7); step("post_rst");

        idle(); set_wr(0, 0, 64'h1234); set_alloc(0); set_rd(0, 0); step("zero_same");
        idle(); set_rd(0, 0); step("zero_next");

        idle(); set_wr(0, 7, 64'h1111); set_wr(1, 7, 64'h2222); step("dual_wr");
        idle(); set_rd(0, 7); step("dual_rd");

        idle(); set_alloc(10); step("alloc10");
        idle(); set_rd(0, 10); set_alloc(10); step("alloc10_stall");
        idle(); set_wr(1, 10, 64'h42); set_alloc(10); set_rd(0, 10); step("wb_alloc10");
        idle(); set_rd(0, 10); step("after_wb");

        idle(); set_wr(0, 3, 64'hC0FFEE); step("wr3");
        idle(); set_alloc(3); step("alloc3");
        idle(); set_alloc(4); step("alloc4");
        idle(); set_alloc(9); step("alloc9");
        idle(); flush = 1'b1; set_alloc(12); step("flush");
        idle(); set_rd(0, 3); set_rd(1, 12); set_rd(2, 9); step("post_flush");

        idle(); set_wr(0, 20, 64'h1); set_alloc(20); step("pre_bypass");
        idle(); set_wr(1, 20, 64'hBEEF); set_rd(2, 20); step("bypass");
        idle(); set_rd(2, 20); step("bypass_next");

        for (int n = 0; n < 400; n++) begin
            idle();
            for (int j = 0; j < NWR; j++)
                if ($urandom_range(1, 0) == 1)
                    set_wr(j, $urandom_range(11, 0), {$urandom, $urandom});
            if ($urandom_range(1, 0) == 1) set_alloc($urandom_range(11, 0));
            flush = ($urandom_range(15, 0) == 0);
            for (int i = 0; i < NRD; i++)
                set_rd(i, ($urandom_range(7, 0) == 0) ? $urandom_range(NREG - 1, 0)
                                                       : $urandom_range(11, 0));
            step("rand");
        end

        idle();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-port register file with an integrated busy-bit scoreboard.
- Next generation of the core's integer/FP register storage: width, depth and port counts are configurable.
- Adds an optional hardwired zero register, multiple write ports with defined priority, and per-register busy tracking for multi-cycle producers (divider, FPU).
- Sits in decode/issue: read ports feed operand fetch, write ports take writeback, the alloc port marks destinations at issue.

Parameters:
- XLEN, 64, data width of each register.
- NREG, 32, number of registers. AW = $clog2(NREG), derived, not overridable.
- NRD, 3, number of read ports. 3 covers fused multiply-add rs3.
- NWR, 2, number of write ports.
- ZERO_REG, 1, 1: register 0 reads zero, ignores writes, is never busy (integer file). 0: register 0 is ordinary (FP file).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rd_addr  in  NRD*AW  read addresses; port i at [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data, combinational.
- rd_busy  out  NRD  busy bit of each addressed register, combinational.
- wr_en  in  NWR  write enables.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- alloc_en  in  1  request to mark alloc_addr busy (issue of a multi-cycle op).
- alloc_addr  in  AW  destination to mark busy.
- alloc_stall  out  1  alloc refused this cycle.
- flush  in  1  synchronous clear of all busy bits.
- busy_vec  out  NREG  raw scoreboard state, for debug and the hazard unit.

Behaviour:
- Reset (rst low, asynchronous): all registers 0, all busy bits 0. Outputs then follow combinationally: rd_data 0, rd_busy 0, busy_vec 0, alloc_stall 0.
- Storage update on posedge clk: for each wr_en[j], reg[wr_addr[j]] <= wr_data[j].
  - Same-address multi-write: the highest-index write port wins.
- Busy clear: a write on any port to address A clears busy[A] at the same edge.
- Busy set: when alloc_en=1 and alloc_stall=0, busy[alloc_addr] is set at the edge.
  - Same edge, alloc and write to the same A: set wins. The data is written and A stays busy (the new producer owns it).
- alloc_stall = alloc_en AND busy[alloc_addr] AND NOT (any wr_en[j] with wr_addr[j]==alloc_addr).
  - Combinational, no state.
  - A stalled alloc has no effect.
  - WAW on a register still in flight is refused until its writeback cycle.
- flush=1: all busy bits clear at the edge and flush takes priority over alloc. Register data is unaffected, and writes in the same cycle still commit.
- ZERO_REG=1, address 0:
  - rd_data 0 and rd_busy 0.
  - Writes dropped.
  - Alloc to 0 never stalls and never sets busy.
  - busy_vec[0] is always 0.
- Out-of-range addresses (NREG not a power of two, addr >= NREG): reads return 0 with busy 0; writes and alloc are ignored.
- Read latency 0 cycles (combinational from rd_addr).
- Write-to-read visibility:
  - With the optional feature enabled: same cycle (bypass).
  - Without it: the following cycle.

Optional Feature:
- REGFILE_BYPASS_EN defined:
  - Each read port compares against all write ports. On a match, rd_data returns that write's wr_data, highest-index port wins, and rd_busy reads 0 for that port in that cycle.
  - Zero-register suppression still applies.
- REGFILE_BYPASS_EN undefined:
  - rd_data and rd_busy reflect registered state only.
  - Decode must hold one extra cycle after writeback.

Test Plan:
- Reset mid-traffic: write reg5=64'hDEAD, pulse rst low between edges -> rd_data for reg5 is 0 immediately and busy_vec=0; post-release reads are all 0.
- Zero register (ZERO_REG=1): write reg0=64'h1234 and alloc reg0 -> reg0 reads 0, rd_busy=0, alloc_stall=0, busy_vec[0]=0.
- Dual-write conflict: port0 writes reg7=64'h1111 and port1 writes reg7=64'h2222 in the same cycle -> reg7 reads 64'h2222 next cycle.
- Scoreboard lifecycle:
  - Alloc reg10 -> rd_busy=1 for reg10 from the next cycle.
  - Second alloc reg10 -> alloc_stall=1.
  - Write reg10=64'h42 -> busy clears at that edge, and that cycle's alloc is not stalled, so reg10 ends busy with data 64'h42.
- Flush: busy set on regs 3, 4 and 9, plus flush with alloc reg12 in the same cycle -> busy_vec=0 next cycle; reg3 data is unchanged.
- Bypass:
  - Defined: write reg20=64'hBEEF and read reg20 in the same cycle -> rd_data=64'hBEEF and rd_busy=0 that cycle.
  - Undefined: the old value that cycle, 64'hBEEF the next.
